// File: rtl/debug_pkg.sv
// Shared types for the debug commit scheduler: run states, halt causes and
// the commit record forwarded to the simulation debug sink.
package debug_pkg;

    localparam int REC_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } dbg_state_e;

    // HOST shares encoding 3 with BREAK; bp_hit tells them apart
    typedef enum logic [1:0] {
        HC_NONE   = 2'd0,
        HC_EBREAK = 2'd1,
        HC_LIMIT  = 2'd2,
        HC_BREAK  = 2'd3
    } halt_cause_e;

    localparam halt_cause_e HC_HOST = HC_BREAK;

    typedef struct packed {
        logic                device_access;
        logic [REC_XLEN-1:0] device_addr;
        logic [REC_XLEN-1:0] pc;
        logic                reg_wen;
        logic [4:0]          reg_waddr;
        logic [REC_XLEN-1:0] reg_wdata;
    } commit_rec_t;

    function automatic logic is_last_step(input logic [31:0] remaining);
        return remaining == 32'd1;
    endfunction

endpackage

// File: rtl/debug_record_reg.sv
// One-cycle output stage for the debug record; fields hold while no
// commit is loaded so the sink sees stable data between records.
module debug_record_reg
    import debug_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        halt,
    input  commit_rec_t rec_in,
    output logic        rec_valid,
    output logic        rec_halt,
    output commit_rec_t rec_out
);

    logic        rec_valid_r;
    logic        rec_halt_r;
    commit_rec_t rec_r;

    // capture the accepted commit; halt can only accompany a valid record
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rec_valid_r <= 1'b0;
            rec_halt_r  <= 1'b0;
            rec_r       <= '0;
        end else begin
            rec_valid_r <= load;
            rec_halt_r  <= load & halt;
            if (load) begin
                rec_r <= rec_in;
            end
        end
    end

    assign rec_valid = rec_valid_r;
    assign rec_halt  = rec_halt_r;
    assign rec_out   = rec_r;

endmodule

// File: rtl/debug_commit_sched.sv
// Commit-to-debug-sink scheduler: sequences free run, step budget, PC
// breakpoint and host stop, and back-pressures the core while halted.
module debug_commit_sched
    import debug_pkg::*;
#(
    parameter int XLEN  = REC_XLEN,
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             host_start,
    input  logic             host_stop,
    input  logic [31:0]      cfg_step_limit,
    input  logic             cfg_bp_en,
    input  logic [XLEN-1:0]  cfg_bp_pc,
    input  logic             commit_valid,
    output logic             commit_ready,
    input  logic             commit_ebreak,
    input  logic             commit_deviceAccess,
    input  logic [XLEN-1:0]  commit_deviceAddr,
    input  logic [XLEN-1:0]  commit_pc,
    input  logic             commit_regWen,
    input  logic [4:0]       commit_regWaddr,
    input  logic [XLEN-1:0]  commit_regWdata,
    output logic             debug_valid,
    output logic             debug_halt,
    output logic             debug_deviceAccess,
    output logic [XLEN-1:0]  debug_deviceAddr,
    output logic [XLEN-1:0]  debug_pc,
    output logic             debug_regWen,
    output logic [4:0]       debug_regWaddr,
    output logic [XLEN-1:0]  debug_regWdata,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic             bp_hit,
    output logic [CNT_W-1:0] retired
);

    dbg_state_e        state_r;
    halt_cause_e       halt_cause_r;
    logic              bp_hit_r;
    logic              skip_bp_r;
    logic [31:0]       remaining_r;
    logic [CNT_W-1:0]  retired_r;

    logic              run_s;
    logic              bp_match_s;
    logic              accept_s;
    logic              last_step_s;
    logic              rec_halt_s;
    commit_rec_t       rec_s;
    logic              out_valid_s;
    logic              out_halt_s;
    commit_rec_t       out_rec_s;

    // a breakpoint match holds the commit back so the halt lands before retire
    always_comb begin
        run_s       = (state_r == ST_RUN);
        bp_match_s  = cfg_bp_en & commit_valid & (commit_pc == cfg_bp_pc) & ~skip_bp_r;
        accept_s    = commit_valid & run_s & ~bp_match_s;
        last_step_s = is_last_step(remaining_r);
        rec_halt_s  = commit_ebreak | last_step_s;
    end

    assign commit_ready = run_s & ~bp_match_s;

    assign rec_s.device_access = commit_deviceAccess;
    assign rec_s.device_addr   = commit_deviceAddr;
    assign rec_s.pc            = commit_pc;
    assign rec_s.reg_wen       = commit_regWen;
    assign rec_s.reg_waddr     = commit_regWaddr;
    assign rec_s.reg_wdata     = commit_regWdata;

    // run-mode sequencer plus retire counter and step budget
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            halt_cause_r <= HC_NONE;
            bp_hit_r     <= 1'b0;
            skip_bp_r    <= 1'b0;
            remaining_r  <= 32'd0;
            retired_r    <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
                skip_bp_r <= 1'b0;
                if (remaining_r != 32'd0) begin
                    remaining_r <= remaining_r - 32'd1;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (host_start) begin
                        state_r     <= ST_RUN;
                        remaining_r <= cfg_step_limit;
                        skip_bp_r   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bp_match_s) begin
                        state_r      <= ST_HALTED;
                        halt_cause_r <= HC_BREAK;
                        bp_hit_r     <= 1'b1;
                        skip_bp_r    <= 1'b1;
                    end else if (accept_s & commit_ebreak) begin
                        state_r      <= ST_HALTED;
                        halt_cause_r <= HC_EBREAK;
                        bp_hit_r     <= 1'b0;
                    end else if (accept_s & last_step_s) begin
                        state_r      <= ST_HALTED;
                        halt_cause_r <= HC_LIMIT;
                        bp_hit_r     <= 1'b0;
                    end else if (host_stop) begin
                        state_r      <= ST_HALTED;
                        halt_cause_r <= HC_HOST;
                        bp_hit_r     <= 1'b0;
                    end
                end
                ST_HALTED: begin
                    // skip_bp survives the resume so the breakpoint PC retires once
                    if (host_start) begin
                        state_r      <= ST_RUN;
                        remaining_r  <= cfg_step_limit;
                        halt_cause_r <= HC_NONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    debug_record_reg u_record (
        .clock     (clock),
        .reset     (reset),
        .load      (accept_s),
        .halt      (rec_halt_s),
        .rec_in    (rec_s),
        .rec_valid (out_valid_s),
        .rec_halt  (out_halt_s),
        .rec_out   (out_rec_s)
    );

    assign debug_valid        = out_valid_s;
    assign debug_halt         = out_halt_s;
    assign debug_deviceAccess = out_rec_s.device_access;
    assign debug_deviceAddr   = out_rec_s.device_addr;
    assign debug_pc           = out_rec_s.pc;
    assign debug_regWen       = out_rec_s.reg_wen;
    assign debug_regWaddr     = out_rec_s.reg_waddr;
    assign debug_regWdata     = out_rec_s.reg_wdata;

    assign state      = state_r;
    assign halt_cause = halt_cause_r;
    assign bp_hit     = bp_hit_r;
    assign retired    = retired_r;

endmodule
